// File: rtl/cu_mc.sv
// Multicycle control unit for the 16-bit core: FETCH/EXEC sequencing with a
// ready-qualified memory handshake, wait-state timeout, halt/resume and sticky error.
module cu_mc #(
  parameter int REG_AW      = 4,
  parameter int TMP_REG     = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           ins_in,
  input  logic                  z_in,
  input  logic                  n_in,
  input  logic                  mem_rdy_in,
  input  logic                  run_in,
  output logic                  il_out,
  output logic [1:0]            ps_out,
  output logic                  rw_out,
  output logic [3*REG_AW-1:0]   rs_out,
  output logic                  mm_out,
  output logic [1:0]            md_out,
  output logic                  mb_out,
  output logic [3:0]            fs_out,
  output logic                  wen_out,
  output logic                  iom_out,
  output logic                  mem_req_out,
  output logic                  halted_out,
  output logic                  err_out,
  output logic [2:0]            dbg_state_out
);

  // Encoding mirrors opcode_t in mycpu_pkg; 7'h00..7'h0F are the plain ALU ops.
  typedef enum logic [6:0] {
    OP_MOVA = 7'h00,
    OP_CLR  = 7'h0F,
    OP_LD   = 7'h10,
    OP_IOR  = 7'h11,
    OP_ST   = 7'h20,
    OP_IOW  = 7'h21,
    OP_ADI  = 7'h42,
    OP_LDI  = 7'h4C,
    OP_BRZ  = 7'h60,
    OP_BRN  = 7'h61,
    OP_JMP  = 7'h70,
    OP_HAL  = 7'h71,
    OP_XXL  = 7'h7F
  } opcode_t;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_XL1   = 3'd3,
    S_HLT   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [6:0]      w_op;
  logic            w_timeout;

  assign w_op          = ins_in[15:9];
  assign dbg_state_out = r_state;
  // Ready in the last tolerated wait cycle still completes; timeout needs not-ready.
  assign w_timeout     = (MEM_TIMEOUT > 0) && (r_cnt == TO_LAST) && !mem_rdy_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || mem_rdy_in)
        r_cnt <= '0;
      else if (mem_req_out)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:   w_next = S_FETCH;
      S_FETCH: begin
        if (mem_rdy_in)     w_next = S_EXEC;
        else if (w_timeout) w_next = S_ERR;
      end
      S_EXEC: begin
        case (w_op) inside
          [OP_MOVA:OP_CLR], OP_LDI, OP_ADI,
          OP_BRZ, OP_BRN, OP_JMP:           w_next = S_FETCH;
          OP_LD, OP_ST, OP_IOR, OP_IOW: begin
            if (mem_rdy_in)     w_next = S_FETCH;
            else if (w_timeout) w_next = S_ERR;
          end
          OP_HAL:                           w_next = S_HLT;
          OP_XXL:                           w_next = S_XL1;
          default:                          w_next = S_ERR;
        endcase
      end
      S_XL1:   w_next = S_FETCH;
      S_HLT:   if (run_in) w_next = S_FETCH;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_RST;
    endcase
  end

  always_comb begin
    il_out      = 1'b0;
    ps_out      = 2'd0;
    rw_out      = 1'b0;
    rs_out      = '0;
    mm_out      = 1'b0;
    md_out      = 2'd0;
    mb_out      = 1'b0;
    fs_out      = 4'd0;
    wen_out     = 1'b1;
    iom_out     = 1'b0;
    mem_req_out = 1'b0;
    halted_out  = 1'b0;
    err_out     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mm_out      = 1'b1;
        mem_req_out = 1'b1;
        il_out      = mem_rdy_in;
      end
      S_EXEC: begin
        fs_out = w_op[3:0];
        rs_out = {REG_AW'(ins_in[8:6]), REG_AW'(ins_in[5:3]), REG_AW'(ins_in[2:0])};
        case (w_op) inside
          [OP_MOVA:OP_CLR]: begin
            rw_out = 1'b1;
            ps_out = 2'd1;
          end
          OP_LDI, OP_ADI: begin
            rw_out = 1'b1;
            ps_out = 2'd1;
            mb_out = 1'b1;
          end
          OP_LD, OP_ST, OP_IOR, OP_IOW: begin
            // Every side effect waits for the ready cycle so it fires exactly once.
            mem_req_out = 1'b1;
            ps_out      = mem_rdy_in ? 2'd1 : 2'd0;
            iom_out     = (w_op == OP_IOR) || (w_op == OP_IOW);
            if ((w_op == OP_LD) || (w_op == OP_IOR)) begin
              md_out = (w_op == OP_LD) ? 2'd1 : 2'd2;
              rw_out = mem_rdy_in;
            end else begin
              wen_out = ~mem_rdy_in;
            end
          end
          OP_BRZ: begin
            fs_out = 4'd0;
            ps_out = z_in ? 2'd2 : 2'd1;
          end
          OP_BRN: begin
            fs_out = 4'd0;
            ps_out = n_in ? 2'd2 : 2'd1;
          end
          OP_JMP: begin
            fs_out = 4'd0;
            ps_out = 2'd3;
          end
          OP_HAL: begin
            fs_out = 4'd0;
            ps_out = 2'd1;
          end
          OP_XXL: begin
            fs_out = 4'b0011;
            rs_out = {REG_AW'(TMP_REG), REG_AW'(1), REG_AW'(2)};
            rw_out = 1'b1;
          end
          default: fs_out = 4'd0;
        endcase
      end
      S_XL1: begin
        fs_out = 4'b0010;
        rs_out = {REG_AW'(0), REG_AW'(0), REG_AW'(TMP_REG)};
        rw_out = 1'b1;
        ps_out = 2'd1;
      end
      S_HLT:   halted_out = 1'b1;
      S_ERR:   err_out    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cu_mc.sv
// Directed bench for cu_mc: one linear sequence of steps, inputs changed just
// after each falling edge and outputs checked 1 ns later.
module tb_cu_mc;

  localparam int REG_AW = 4;

  localparam logic [2:0] S_RST = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2,
                         S_XL1 = 3'd3, S_HLT = 3'd4, S_ERR = 3'd5;

  localparam logic [6:0] OP_MOVA = 7'h00, OP_ADD = 7'h02, OP_LD = 7'h10,
                         OP_IOR = 7'h11, OP_ST = 7'h20, OP_IOW = 7'h21,
                         OP_LDI = 7'h4C, OP_BRZ = 7'h60, OP_BRN = 7'h61,
                         OP_JMP = 7'h70, OP_HAL = 7'h71, OP_XXL = 7'h7F,
                         OP_BAD = 7'h3F;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [15:0]         ins_in;
  logic                z_in, n_in, mem_rdy_in, run_in;
  logic                il_out, rw_out, mm_out, mb_out, wen_out, iom_out;
  logic                mem_req_out, halted_out, err_out;
  logic [1:0]          ps_out, md_out;
  logic [3:0]          fs_out;
  logic [3*REG_AW-1:0] rs_out;
  logic [2:0]          dbg_state_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cu_mc #(.REG_AW(REG_AW), .TMP_REG(8), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .ins_in(ins_in), .z_in(z_in), .n_in(n_in),
    .mem_rdy_in(mem_rdy_in), .run_in(run_in), .il_out(il_out), .ps_out(ps_out),
    .rw_out(rw_out), .rs_out(rs_out), .mm_out(mm_out), .md_out(md_out),
    .mb_out(mb_out), .fs_out(fs_out), .wen_out(wen_out), .iom_out(iom_out),
    .mem_req_out(mem_req_out), .halted_out(halted_out), .err_out(err_out),
    .dbg_state_out(dbg_state_out)
  );

  function automatic logic [15:0] mk(input logic [6:0] op, input logic [2:0] d,
                                     input logic [2:0] a, input logic [2:0] b);
    return {op, d, a, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Default output values: everything 0 except wen_out.
  task automatic chk_idle(input string tag);
    chk({tag, ".il"},  32'(il_out), 0);
    chk({tag, ".ps"},  32'(ps_out), 0);
    chk({tag, ".rw"},  32'(rw_out), 0);
    chk({tag, ".rs"},  32'(rs_out), 0);
    chk({tag, ".mm"},  32'(mm_out), 0);
    chk({tag, ".md"},  32'(md_out), 0);
    chk({tag, ".mb"},  32'(mb_out), 0);
    chk({tag, ".fs"},  32'(fs_out), 0);
    chk({tag, ".wen"}, 32'(wen_out), 1);
    chk({tag, ".iom"}, 32'(iom_out), 0);
    chk({tag, ".req"}, 32'(mem_req_out), 0);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1; #1;
    chk("rst.state_after_release", 32'(dbg_state_out), S_RST);
    cyc(); #1;
    chk("rst.to_fetch", 32'(dbg_state_out), S_FETCH);
  endtask

  initial begin
    rst_n = 1'b0; ins_in = '0; z_in = 1'b0; n_in = 1'b0; mem_rdy_in = 1'b0; run_in = 1'b0;
    repeat (2) cyc();
    #1;
    chk("reset.state", 32'(dbg_state_out), S_RST);
    chk_idle("reset");
    chk("reset.halted", 32'(halted_out), 0);
    chk("reset.err", 32'(err_out), 0);

    // ADD R3,R1,R2 with zero-wait memory
    cyc(); rst_n = 1'b1; mem_rdy_in = 1'b1; ins_in = mk(OP_ADD, 3'd3, 3'd1, 3'd2); #1;
    chk("rel.state", 32'(dbg_state_out), S_RST);
    cyc(); #1;
    chk("add.f.state", 32'(dbg_state_out), S_FETCH);
    chk("add.f.il", 32'(il_out), 1);
    chk("add.f.mm", 32'(mm_out), 1);
    chk("add.f.req", 32'(mem_req_out), 1);
    cyc(); #1;
    chk("add.e.state", 32'(dbg_state_out), S_EXEC);
    chk("add.e.rs", 32'(rs_out), 32'h312);
    chk("add.e.rw", 32'(rw_out), 1);
    chk("add.e.ps", 32'(ps_out), 1);
    chk("add.e.fs", 32'(fs_out), 2);
    chk("add.e.req", 32'(mem_req_out), 0);

    // LD R5,R4 stalled 3 cycles
    cyc(); ins_in = mk(OP_LD, 3'd5, 3'd4, 3'd0); #1;
    chk("ld.f.state", 32'(dbg_state_out), S_FETCH);
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_rdy_in = 1'b0; #1;
      chk("ld.w.state", 32'(dbg_state_out), S_EXEC);
      chk("ld.w.req", 32'(mem_req_out), 1);
      chk("ld.w.rw", 32'(rw_out), 0);
      chk("ld.w.ps", 32'(ps_out), 0);
    end
    cyc(); mem_rdy_in = 1'b1; #1;
    chk("ld.r.md", 32'(md_out), 1);
    chk("ld.r.rw", 32'(rw_out), 1);
    chk("ld.r.ps", 32'(ps_out), 1);

    // ST stalled 2 cycles
    cyc(); ins_in = mk(OP_ST, 3'd0, 3'd2, 3'd3); #1;
    chk("st.f.state", 32'(dbg_state_out), S_FETCH);
    for (int i = 0; i < 2; i++) begin
      cyc(); mem_rdy_in = 1'b0; #1;
      chk("st.w.wen", 32'(wen_out), 1);
      chk("st.w.ps", 32'(ps_out), 0);
    end
    cyc(); mem_rdy_in = 1'b1; #1;
    chk("st.r.wen", 32'(wen_out), 0);
    chk("st.r.ps", 32'(ps_out), 1);
    chk("st.r.iom", 32'(iom_out), 0);

    // IOW stalled 1 cycle
    cyc(); ins_in = mk(OP_IOW, 3'd0, 3'd1, 3'd0); #1;
    cyc(); mem_rdy_in = 1'b0; #1;
    chk("iow.w.wen", 32'(wen_out), 1);
    chk("iow.w.iom", 32'(iom_out), 1);
    cyc(); mem_rdy_in = 1'b1; #1;
    chk("iow.r.wen", 32'(wen_out), 0);
    chk("iow.r.iom", 32'(iom_out), 1);

    // IOR zero wait
    cyc(); ins_in = mk(OP_IOR, 3'd6, 3'd0, 3'd0); #1;
    cyc(); #1;
    chk("ior.md", 32'(md_out), 2);
    chk("ior.iom", 32'(iom_out), 1);
    chk("ior.rw", 32'(rw_out), 1);

    // Branches and jump
    cyc(); ins_in = mk(OP_BRZ, 3'd0, 3'd0, 3'd5); z_in = 1'b1; #1;
    cyc(); #1;
    chk("brz.taken.ps", 32'(ps_out), 2);
    chk("brz.fs", 32'(fs_out), 0);
    cyc(); z_in = 1'b0; #1;
    cyc(); #1;
    chk("brz.not.ps", 32'(ps_out), 1);
    cyc(); ins_in = mk(OP_BRN, 3'd0, 3'd0, 3'd1); n_in = 1'b1; #1;
    cyc(); #1;
    chk("brn.taken.ps", 32'(ps_out), 2);
    cyc(); n_in = 1'b0; ins_in = mk(OP_JMP, 3'd0, 3'd7, 3'd0); #1;
    cyc(); #1;
    chk("jmp.ps", 32'(ps_out), 3);
    chk("jmp.rw", 32'(rw_out), 0);

    // XXL: FMUL into R8, then R0 = R0 + R8
    cyc(); ins_in = mk(OP_XXL, 3'd0, 3'd0, 3'd0); #1;
    cyc(); #1;
    chk("xxl.fs", 32'(fs_out), 3);
    chk("xxl.rs", 32'(rs_out), 32'h812);
    chk("xxl.rw", 32'(rw_out), 1);
    chk("xxl.ps", 32'(ps_out), 0);
    cyc(); #1;
    chk("xl1.state", 32'(dbg_state_out), S_XL1);
    chk("xl1.fs", 32'(fs_out), 2);
    chk("xl1.rs", 32'(rs_out), 32'h008);
    chk("xl1.rw", 32'(rw_out), 1);
    chk("xl1.ps", 32'(ps_out), 1);
    cyc(); ins_in = mk(OP_LDI, 3'd2, 3'd0, 3'd7); #1;
    chk("xl1.to_fetch", 32'(dbg_state_out), S_FETCH);
    cyc(); #1;
    chk("ldi.mb", 32'(mb_out), 1);
    chk("ldi.fs", 32'(fs_out), 4'hC);
    chk("ldi.rs", 32'(rs_out), 32'h207);

    // HAL, idle while halted, resume on run_in
    cyc(); ins_in = mk(OP_HAL, 3'd0, 3'd0, 3'd0); #1;
    cyc(); #1;
    chk("hal.ps", 32'(ps_out), 1);
    chk("hal.fs", 32'(fs_out), 0);
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      chk("hlt.halted", 32'(halted_out), 1);
      chk("hlt.state", 32'(dbg_state_out), S_HLT);
      chk_idle("hlt");
    end
    cyc(); run_in = 1'b1; #1;
    chk("run.still_halted", 32'(halted_out), 1);
    cyc(); run_in = 1'b0; #1;
    chk("run.state", 32'(dbg_state_out), S_FETCH);
    chk("run.halted", 32'(halted_out), 0);

    // Ready in wait cycle 15 of a fetch completes normally
    ins_in = mk(OP_MOVA, 3'd1, 3'd1, 3'd0); mem_rdy_in = 1'b0; #1;
    chk("near.w1.il", 32'(il_out), 0);
    for (int i = 2; i <= 14; i++) begin
      cyc(); #1;
      chk("near.w.state", 32'(dbg_state_out), S_FETCH);
    end
    cyc(); mem_rdy_in = 1'b1; #1;
    chk("near.w15.il", 32'(il_out), 1);
    cyc(); #1;
    chk("near.exec", 32'(dbg_state_out), S_EXEC);
    chk("near.exec.rw", 32'(rw_out), 1);

    // Reset mid-wait drops outputs immediately
    cyc(); mem_rdy_in = 1'b0; #1;
    cyc(); #1;
    chk("midrst.pre.req", 32'(mem_req_out), 1);
    #2; rst_n = 1'b0; #1;
    chk("midrst.state", 32'(dbg_state_out), S_RST);
    chk_idle("midrst");
    cyc(); rst_n = 1'b1; #1;
    cyc(); #1;
    chk("midrst.fetch", 32'(dbg_state_out), S_FETCH);

    // Fifteen not-ready fetch cycles then ERR, which is sticky
    for (int i = 2; i <= 15; i++) begin
      cyc(); #1;
      chk("to.w.state", 32'(dbg_state_out), S_FETCH);
    end
    cyc(); #1;
    chk("to.err.state", 32'(dbg_state_out), S_ERR);
    chk("to.err", 32'(err_out), 1);
    chk_idle("to.err");
    cyc(); mem_rdy_in = 1'b1; run_in = 1'b1; #1;
    cyc(); #1;
    chk("to.err.sticky", 32'(err_out), 1);
    run_in = 1'b0;

    // Undefined opcode
    do_reset();
    ins_in = mk(OP_BAD, 3'd1, 3'd2, 3'd3);
    cyc(); #1;
    chk("bad.fs", 32'(fs_out), 0);
    chk("bad.err_exec", 32'(err_out), 0);
    cyc(); #1;
    chk("bad.err", 32'(err_out), 1);
    cyc(); #1;
    chk("bad.err.sticky", 32'(err_out), 1);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
